// File: rtl/uart_pixel_rx.sv
// -----------------------------------------------------------------------------
// uart_pixel_rx
//
// Serial front end of the image-load path. Receives 8N1 UART bytes on rx and
// presents each accepted byte on pixel together with a toggle strobe
// (new_data). receive stays high while an image is loading; after IMAGE_BYTES
// good bytes and a DONE_HOLD-cycle tail, receive drops, done rises and the
// block ignores the line until reset.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 8)
//   IMAGE_BYTES   bytes per image (<= 8192)
//   DONE_HOLD     cycles receive stays high after the final toggle (>= 4)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx           asynchronous UART line, idles high
//   pixel        last accepted byte, stable between new_data toggles
//   new_data     toggles once per accepted byte
//   receive      high while loading an image
//   frame_error  one-cycle pulse on a bad stop bit
//   done         sticky once IMAGE_BYTES bytes are accepted
//   byte_count   accepted bytes, 0 .. IMAGE_BYTES
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every start/data/stop sample is a 2-of-3
//                        vote of the synchronized line at centre -1/0/+1.
//                        Output timing is identical in both builds.
// -----------------------------------------------------------------------------
module uart_pixel_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int IMAGE_BYTES  = 8192,
   parameter int DONE_HOLD    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic [7:0]  pixel,
   output logic        new_data,
   output logic        receive,
   output logic        frame_error,
   output logic        done,
   output logic [13:0] byte_count
);

   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam int HW = $clog2(DONE_HOLD + 1);

   localparam logic [TW-1:0] TMR_HALF   = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0] TMR_RELOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TMR_ONE    = TW'(1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(DONE_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
   localparam logic [13:0]   IMAGE_MAX  = 14'(IMAGE_BYTES);
   localparam logic [13:0]   IMAGE_LAST = 14'(IMAGE_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_RECOVER,
      S_HOLD,
      S_FINISHED
   } state_e;

   // Synchronizer and sample history
   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_dly1_q;
`ifdef UART_RX_MAJORITY_EN
   logic rx_dly2_q;
`endif

   // Sampled line value used at each decision edge. Decisions are taken one
   // cycle after the nominal bit centre, so the centre sample is rx_dly1_q and
   // the +1 sample (rx_sync_q) is already available without extra latency.
   logic line_bit;

   // FSM and datapath
   state_e          state_q;
   logic [TW-1:0]   timer_q;
   logic [HW-1:0]   hold_q;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic [7:0]      pixel_q;
   logic            new_data_q;
   logic            receive_q;
   logic            frame_err_q;
   logic            done_q;
   logic [13:0]     byte_count_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_dly1_q <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
         rx_dly2_q <= 1'b1;
`endif
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_dly1_q <= rx_sync_q;
`ifdef UART_RX_MAJORITY_EN
         rx_dly2_q <= rx_dly1_q;
`endif
      end
   end

`ifdef UART_RX_MAJORITY_EN
   assign line_bit = (rx_dly2_q & rx_dly1_q) |
                     (rx_dly2_q & rx_sync_q) |
                     (rx_dly1_q & rx_sync_q);
`else
   assign line_bit = rx_dly1_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         hold_q       <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         pixel_q      <= '0;
         new_data_q   <= 1'b0;
         receive_q    <= 1'b1;
         frame_err_q  <= 1'b0;
         done_q       <= 1'b0;
         byte_count_q <= '0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            // IDLE is only entered with the line high, so a low synchronized
            // level here is a falling edge, including one that arrived while
            // the previous stop bit was still being evaluated.
            S_IDLE: begin
               if (!rx_sync_q) begin
                  timer_q <= TMR_HALF;
                  state_q <= S_START;
               end
            end

            S_START: begin
               if (timer_q == '0) begin
                  if (!line_bit) begin
                     timer_q   <= TMR_RELOAD;
                     bit_idx_q <= '0;
                     state_q   <= S_DATA;
                  end else begin
                     state_q   <= S_IDLE;   // glitch: no output change
                  end
               end else begin
                  timer_q <= timer_q - TMR_ONE;
               end
            end

            S_DATA: begin
               if (timer_q == '0) begin
                  shift_q <= {line_bit, shift_q[7:1]};   // LSB first
                  timer_q <= TMR_RELOAD;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  timer_q <= timer_q - TMR_ONE;
               end
            end

            S_STOP: begin
               if (timer_q == '0) begin
                  if (line_bit) begin
                     pixel_q    <= shift_q;
                     new_data_q <= ~new_data_q;
                     if (byte_count_q != IMAGE_MAX) begin
                        byte_count_q <= byte_count_q + 14'd1;
                     end
                     if (byte_count_q == IMAGE_LAST) begin
                        hold_q  <= HOLD_LOAD;
                        state_q <= S_HOLD;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     frame_err_q <= 1'b1;      // byte discarded
                     state_q     <= S_RECOVER;
                  end
               end else begin
                  timer_q <= timer_q - TMR_ONE;
               end
            end

            // A held-low line (break) parks here and never yields a byte.
            S_RECOVER: begin
               if (rx_sync_q) begin
                  state_q <= S_IDLE;
               end
            end

            S_HOLD: begin
               if (hold_q == '0) begin
                  receive_q <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_FINISHED;
               end else begin
                  hold_q <= hold_q - HOLD_ONE;
               end
            end

            S_FINISHED: begin
               // Line ignored, outputs frozen until reset.
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pixel       = pixel_q;
   assign new_data    = new_data_q;
   assign receive     = receive_q;
   assign frame_error = frame_err_q;
   assign done        = done_q;
   assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_uart_pixel_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_pixel_rx
//
// Self-checking bench for uart_pixel_rx with CLKS_PER_BIT=16, IMAGE_BYTES=4,
// DONE_HOLD=8. Frames are driven on rx a bit-period at a time; a reference
// model tracks, per frame, what the receiver must have produced (byte count,
// last pixel, number of strobes, number of framing errors). A negedge monitor
// observes the DUT strobes independently.
// -----------------------------------------------------------------------------
module tb_uart_pixel_rx;

   localparam int CPB  = 16;
   localparam int H    = CPB / 2;
   localparam int IMG  = 4;
   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [7:0]  pixel;
   logic        new_data;
   logic        receive;
   logic        frame_error;
   logic        done;
   logic [13:0] byte_count;

   uart_pixel_rx #(
      .CLKS_PER_BIT (CPB),
      .IMAGE_BYTES  (IMG),
      .DONE_HOLD    (HOLD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .pixel       (pixel),
      .new_data    (new_data),
      .receive     (receive),
      .frame_error (frame_error),
      .done        (done),
      .byte_count  (byte_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: counts strobe toggles, frame_error cycles and receive falls.
   int   tog_cnt;
   int   ferr_cnt;
   int   tog_cyc;
   int   recv_fall_cyc;
   logic nd_prev;
   logic recv_prev;

   always @(negedge clk) begin
      if (!reset) begin
         tog_cnt       <= 0;
         ferr_cnt      <= 0;
         tog_cyc       <= 0;
         recv_fall_cyc <= -1;
         nd_prev       <= 1'b0;
         recv_prev     <= 1'b1;
      end else begin
         nd_prev   <= new_data;
         recv_prev <= receive;
         if (new_data !== nd_prev) begin
            tog_cnt <= tog_cnt + 1;
            tog_cyc <= cyc;
         end
         if (frame_error) ferr_cnt <= ferr_cnt + 1;
         if (recv_prev && !receive) recv_fall_cyc <= cyc;
      end
   end

   // Bookkeeping
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference model
   int         m_count;
   logic [7:0] m_pixel;
   int         m_tog;
   int         m_ferr;

   task automatic model_reset();
      m_count = 0;
      m_pixel = 8'h00;
      m_tog   = 0;
      m_ferr  = 0;
   endtask

   // Once IMAGE_BYTES bytes are in, the receiver ignores all traffic.
   task automatic model_frame(input logic [7:0] d, input logic stop_ok);
      if (m_count < IMG) begin
         if (stop_ok) begin
            m_count++;
            m_pixel = d;
            m_tog++;
         end else begin
            m_ferr++;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_count"}, 32'(byte_count), 32'(m_count));
      check({tag, "_pixel"}, 32'(pixel), 32'(m_pixel));
      check({tag, "_toggles"}, 32'(tog_cnt), 32'(m_tog));
      check({tag, "_ferr"}, 32'(ferr_cnt), 32'(m_ferr));
   endtask

   // Stimulus helpers; all drive at posedge + 1.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one 10-bit frame; spike_at >= 0 inverts the line for one cycle at
   // that cycle offset within the frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_b,
                             input int spike_at, output int fall_cyc);
      logic [9:0] bits;
      bits     = {stop_b, d, 1'b0};
      fall_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < CPB; j++) begin
            rx = ((i * CPB + j) == spike_at) ? ~bits[i] : bits[i];
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic assert_reset(input int n);
      reset = 1'b0;
      idle(n);
   endtask

   task automatic release_reset();
      reset = 1'b1;
      model_reset();
      idle(1);
   endtask

   initial begin
      int         fc;
      int         lat;
      logic [7:0] d;
      logic       ok;
      logic [7:0] last_good;

      reset = 1'b0;
      rx    = 1'b1;
      model_reset();
      idle(4);
      release_reset();

      // ---- Reset mid-byte, release with the line held low ----------------
      rx = 1'b0;
      idle(3 * CPB);
      assert_reset(3);
      check("rst_pixel", 32'(pixel), 32'h0);
      check("rst_new_data", 32'(new_data), 32'h0);
      check("rst_receive", 32'(receive), 32'h1);
      check("rst_frame_error", 32'(frame_error), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_byte_count", 32'(byte_count), 32'h0);
      release_reset();
      idle(20 * CPB);
      check("held_low_toggles", 32'(tog_cnt), 32'h0);
      check("held_low_count", 32'(byte_count), 32'h0);
      rx = 1'b1;
      idle(2 * CPB);

      // ---- 0xA5 with latency check ---------------------------------------
      // Frame counters from the low line above are not part of this image.
      model_reset();
      m_ferr = ferr_cnt;
      send_frame(8'hA5, 1'b1, -1, fc);
      model_frame(8'hA5, 1'b1);
      check_model("a5");
      check("a5_new_data", 32'(new_data), 32'h1);
      lat = tog_cyc - fc;
      check("a5_latency", 32'((lat >= 2 + H + 9 * CPB) && (lat <= 2 + H + 9 * CPB + 2)), 32'h1);

      // ---- Back-to-back 0x00, 0xFF with one stop bit ---------------------
      send_frame(8'h00, 1'b1, -1, fc);
      model_frame(8'h00, 1'b1);
      check_model("b2b_00");
      send_frame(8'hFF, 1'b1, -1, fc);
      model_frame(8'hFF, 1'b1);
      check_model("b2b_ff");
      idle(2 * CPB);

      // ---- Framing error, break, recovery --------------------------------
      assert_reset(2);
      release_reset();
      send_frame(8'h3C, 1'b0, -1, fc);
      model_frame(8'h3C, 1'b0);
      rx = 1'b1;
      idle(2 * CPB);
      check_model("ferr_3c");
      rx = 1'b0;
      idle(40 * CPB);
      model_frame(8'h00, 1'b0);   // a break first looks like a frame with a low stop bit
      rx = 1'b1;
      idle(2 * CPB);
      check_model("break");
      send_frame(8'h11, 1'b1, -1, fc);
      model_frame(8'h11, 1'b1);
      check_model("after_break_11");

      // ---- Three-cycle low glitch ----------------------------------------
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(2 * CPB);
      check_model("glitch");

`ifdef UART_RX_MAJORITY_EN
      // ---- Single-cycle spike at the centre of data bit 2 of 0x55 ---------
      send_frame(8'h55, 1'b1, 3 * CPB + H, fc);
      model_frame(8'h55, 1'b1);
      check_model("spike_55");
      idle(CPB);
`endif

      // ---- Randomized frames against the model ---------------------------
      assert_reset(2);
      release_reset();
      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(3) != 0);
         send_frame(d, ok, -1, fc);
         model_frame(d, ok);
         check_model($sformatf("rnd%0d", n));
         rx = 1'b1;
         idle(ok ? $urandom_range(0, 20) : CPB + $urandom_range(0, 20));
      end
      idle(2 * HOLD);
      check("rnd_done", 32'(done), 32'(m_count == IMG));
      check("rnd_receive", 32'(receive), 32'(m_count != IMG));

      // ---- Image completion: 5 bytes into a 4-byte image -----------------
      assert_reset(2);
      release_reset();
      last_good = 8'h00;
      for (int n = 0; n < 5; n++) begin
         d = 8'($urandom);
         if (n == IMG - 1) last_good = d;
         send_frame(d, 1'b1, -1, fc);
         model_frame(d, 1'b1);
      end
      idle(2 * CPB);
      check("img_toggles", 32'(tog_cnt), 32'(IMG));
      check("img_pixel", 32'(pixel), 32'(last_good));
      check("img_count", 32'(byte_count), 32'(IMG));
      check("img_done", 32'(done), 32'h1);
      check("img_receive", 32'(receive), 32'h0);
      check("img_hold_cycles", 32'(recv_fall_cyc - tog_cyc), 32'(HOLD));
      check_model("img");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
